// File: rtl/stg_pkg.sv
// Shared STG playfield constants: screen geometry, ship spawn point,
// laser state encoding and the sprite transparent colour.
package stg_pkg;

  localparam int MAX_X   = 384;
  localparam int MAX_Y   = 448;
  localparam int SPAWN_X = MAX_X / 2;
  localparam int SPAWN_Y = MAX_Y - 48;

  typedef enum logic [1:0] {
    LASER_IDLE   = 2'd0,
    LASER_CHARGE = 2'd1,
    LASER_FIRE   = 2'd2,
    LASER_COOL   = 2'd3
  } laser_state_t;

  localparam logic [11:0] TRANSPARENT = 12'h000;

  // a - b through an 11-bit signed intermediate, floored at zero instead of wrapping
  function automatic logic [9:0] clamp_sub(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[10] ? 10'd0 : d[9:0];
  endfunction

endpackage

// File: rtl/laser_beam_ctrl_if.sv
// Pixel/ROM/control bundle between the playfield mixer (master) and the
// laser beam controller (slave).
interface laser_beam_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [9:0]        x;
  logic [9:0]        y;
  logic [9:0]        player_x;
  logic [9:0]        player_y;
  logic              shooting;
  logic [ADDR_W-1:0] rom_addr;
  logic [11:0]       rom_rgb;
  logic [11:0]       rgb_out;
  logic              laser_on;
  logic [1:0]        state;
  logic [9:0]        beam_len;

  modport master (
    output x, y, player_x, player_y, shooting, rom_rgb,
    input  rom_addr, rgb_out, laser_on, state, beam_len
  );

  modport slave (
    input  x, y, player_x, player_y, shooting, rom_rgb,
    output rom_addr, rgb_out, laser_on, state, beam_len
  );
endinterface

// File: rtl/game_tick_gen.sv
// Game tick prescaler: tick is high for one clk cycle every TICK_CYCLES cycles.
module game_tick_gen #(
  parameter int TICK_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Free-running cycle counter wrapping at TICK_CYCLES-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (count_r == LAST) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CW'(1);
    end
  end

  assign tick = (count_r == LAST);

endmodule

// File: rtl/laser_beam_ctrl.sv
// Multi-beam player laser: tick-driven charge/fire/overheat/cooldown FSM plus
// a per-pixel combinational hit test that addresses the beam sprite ROM.
module laser_beam_ctrl #(
  parameter int MAX_X        = stg_pkg::MAX_X,
  parameter int MAX_Y        = stg_pkg::MAX_Y,
  parameter int TICK_CYCLES  = 2000000,
  parameter int BEAM_W       = 16,
  parameter int SPR_H        = 16,
  parameter int NUM_BEAMS    = 3,
  parameter int BEAM_SPACING = 20,
  parameter int GROW_STEP    = 32,
  parameter int CHARGE_TICKS = 8,
  parameter int FIRE_TICKS   = 60,
  parameter int COOL_TICKS   = 30
) (
  input  logic             clk,
  input  logic             reset,
  laser_beam_ctrl_if.slave bus
);
  import stg_pkg::*;

  localparam int BW_LOG  = $clog2(BEAM_W);
  localparam int SH_LOG  = $clog2(SPR_H);
  localparam int HALF    = (NUM_BEAMS - 1) / 2;
  localparam int CNT_MAX = (FIRE_TICKS > CHARGE_TICKS) ?
                           ((FIRE_TICKS > COOL_TICKS) ? FIRE_TICKS : COOL_TICKS) :
                           ((CHARGE_TICKS > COOL_TICKS) ? CHARGE_TICKS : COOL_TICKS);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [9:0]         ORIGIN_X_RST = 10'(MAX_X / 2 - BEAM_W / 2);
  localparam logic [9:0]         ORIGIN_Y_RST = 10'(MAX_Y - 49);
  localparam logic signed [12:0] BW_S         = 13'(BEAM_W);
  localparam logic signed [12:0] MAXX_S       = 13'(MAX_X);

  laser_state_t       state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [9:0]         beam_len_r;
  logic [9:0]         origin_x_r;
  logic [9:0]         origin_y_r;
  logic               tick_s;
  logic [10:0]        grow_sum_s;
  logic [9:0]         grow_len_s;
  logic [9:0]         entry_len_s;
  logic signed [12:0] px_s;
  logic signed [12:0] py_s;
  logic signed [12:0] oy_s;
  logic signed [12:0] top_s;
  logic signed [12:0] off_s;
  logic signed [12:0] bx_s;
  logic               hit_s;
  logic [BW_LOG-1:0]  dx_s;

  game_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  // Beam length candidates, both saturated at origin_y so the beam stops at row 0
  always_comb begin
    grow_sum_s = {1'b0, beam_len_r} + 11'(GROW_STEP);
    if (grow_sum_s > {1'b0, origin_y_r}) begin
      grow_len_s = origin_y_r;
    end else begin
      grow_len_s = grow_sum_s[9:0];
    end
    if (11'(GROW_STEP) > {1'b0, origin_y_r}) begin
      entry_len_s = origin_y_r;
    end else begin
      entry_len_s = 10'(GROW_STEP);
    end
  end

  // Anchor latch and laser FSM, advanced only on game ticks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= LASER_IDLE;
      cnt_r      <= '0;
      beam_len_r <= 10'd0;
      origin_x_r <= ORIGIN_X_RST;
      origin_y_r <= ORIGIN_Y_RST;
    end else if (tick_s) begin
      origin_x_r <= clamp_sub(bus.player_x, 10'(BEAM_W / 2));
      origin_y_r <= clamp_sub(bus.player_y, 10'd1);
      case (state_r)
        LASER_IDLE: begin
          if (bus.shooting) begin
            state_r <= LASER_CHARGE;
            cnt_r   <= '0;
          end
        end
        LASER_CHARGE: begin
          if (!bus.shooting) begin
            state_r <= LASER_IDLE;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_W'(CHARGE_TICKS - 1)) begin
            state_r    <= LASER_FIRE;
            cnt_r      <= '0;
            beam_len_r <= entry_len_s;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        LASER_FIRE: begin
          // Release or overheat: the grown length is never visible outside FIRE,
          // so the beam collapses on the same tick it leaves FIRE.
          if (!bus.shooting || (cnt_r == CNT_W'(FIRE_TICKS - 1))) begin
            state_r    <= LASER_COOL;
            cnt_r      <= '0;
            beam_len_r <= 10'd0;
          end else begin
            cnt_r      <= cnt_r + CNT_W'(1);
            beam_len_r <= grow_len_s;
          end
        end
        LASER_COOL: begin
          beam_len_r <= 10'd0;
          if (cnt_r == CNT_W'(COOL_TICKS - 1)) begin
            state_r <= LASER_IDLE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r    <= LASER_IDLE;
          cnt_r      <= '0;
          beam_len_r <= 10'd0;
        end
      endcase
    end
  end

  // Hit test over all beams; iterating downwards lets the lowest index win overlaps
  always_comb begin
    px_s  = $signed({3'b000, bus.x});
    py_s  = $signed({3'b000, bus.y});
    oy_s  = $signed({3'b000, origin_y_r});
    top_s = oy_s - $signed({3'b000, beam_len_r});
    off_s = 13'sd0;
    bx_s  = 13'sd0;
    hit_s = 1'b0;
    dx_s  = '0;
    for (int k = NUM_BEAMS - 1; k >= 0; k--) begin
      off_s = 13'((k - HALF) * BEAM_SPACING);
      bx_s  = $signed({3'b000, origin_x_r}) + off_s;
      if ((bx_s >= 13'sd0) && ((bx_s + BW_S) <= MAXX_S) &&
          (px_s >= bx_s) && (px_s < (bx_s + BW_S)) &&
          (py_s >= top_s) && (py_s < oy_s)) begin
        hit_s = 1'b1;
        dx_s  = bus.x[BW_LOG-1:0] - bx_s[BW_LOG-1:0];
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Pixel outputs are combinational so the mixer sees them in the same cycle as x/y
  always_comb begin
    if (hit_s) begin
      bus.rom_addr = {bus.y[SH_LOG-1:0], dx_s};
    end else begin
      bus.rom_addr = '0;
    end
    bus.laser_on = hit_s && (state_r == LASER_FIRE) && (bus.rom_rgb != TRANSPARENT);
    bus.rgb_out  = bus.rom_rgb;
    bus.state    = state_r;
    bus.beam_len = beam_len_r;
  end

endmodule

// File: tb/tb_laser_beam_ctrl.sv
// Self-checking bench for laser_beam_ctrl with a short tick period.
module tb_laser_beam_ctrl;
  import stg_pkg::*;

  localparam int TB_TICK = 4;

  typedef struct packed {
    logic [9:0]  px;
    logic [9:0]  py;
    logic [11:0] rgb;
    logic        on;
    logic [7:0]  addr;
  } pix_vec_t;

  typedef struct packed {
    logic [1:0]  st;
    logic [9:0]  len;
    logic        on;
    logic [7:0]  addr;
    logic [11:0] rgb;
  } exp_t;

  logic     clk;
  logic     reset;
  int       total_cnt;
  int       bad_cnt;
  exp_t     sb_q[$];
  pix_vec_t fire_tab[10];

  laser_beam_ctrl_if #(.ADDR_W(8)) bus ();

  laser_beam_ctrl #(
    .TICK_CYCLES  (TB_TICK),
    .CHARGE_TICKS (2),
    .FIRE_TICKS   (4),
    .COOL_TICKS   (2),
    .GROW_STEP    (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act !== expv) begin
      bad_cnt++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  task automatic check_pix(input string nm, input logic [9:0] px, input logic [9:0] py,
                           input logic [11:0] rgb, input logic eon, input logic [7:0] eaddr,
                           input logic [1:0] est, input logic [9:0] elen);
    exp_t e;
    exp_t g;
    bus.x = px;
    bus.y = py;
    bus.rom_rgb = rgb;
    e.st = est; e.len = elen; e.on = eon; e.addr = eaddr; e.rgb = rgb;
    sb_q.push_back(e);
    #1;
    g = sb_q.pop_front();
    cmp({nm, ".laser_on"}, 32'(bus.laser_on), 32'(g.on));
    cmp({nm, ".rom_addr"}, 32'(bus.rom_addr), 32'(g.addr));
    cmp({nm, ".rgb_out"},  32'(bus.rgb_out),  32'(g.rgb));
    cmp({nm, ".state"},    32'(bus.state),    32'(g.st));
    cmp({nm, ".beam_len"}, 32'(bus.beam_len), 32'(g.len));
  endtask

  task automatic run_ticks(input int n);
    repeat (TB_TICK * n) @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    // origin (184,399), beam_len 32: beams at x 164/184/204, rows 367..398
    fire_tab[0] = '{10'd184, 10'd390, 12'hF00, 1'b1, 8'h60};
    fire_tab[1] = '{10'd184, 10'd300, 12'hF00, 1'b0, 8'h00};
    fire_tab[2] = '{10'd164, 10'd367, 12'h0F0, 1'b1, 8'hF0};
    fire_tab[3] = '{10'd179, 10'd398, 12'h00F, 1'b1, 8'hEF};
    fire_tab[4] = '{10'd180, 10'd380, 12'hF00, 1'b0, 8'h00};
    fire_tab[5] = '{10'd219, 10'd370, 12'h123, 1'b1, 8'h2F};
    fire_tab[6] = '{10'd220, 10'd370, 12'hF00, 1'b0, 8'h00};
    fire_tab[7] = '{10'd190, 10'd399, 12'hF00, 1'b0, 8'h00};
    fire_tab[8] = '{10'd190, 10'd366, 12'hF00, 1'b0, 8'h00};
    fire_tab[9] = '{10'd190, 10'd380, 12'h000, 1'b0, 8'hC6};

    reset = 1'b1;
    bus.x = 10'd0; bus.y = 10'd0; bus.rom_rgb = 12'h000;
    bus.player_x = 10'(SPAWN_X); bus.player_y = 10'(SPAWN_Y);
    bus.shooting = 1'b0;
    run_cycles(3);
    check_pix("rst_idle", 10'd0, 10'd0, 12'h000, 1'b0, 8'h00, 2'd0, 10'd0);
    check_pix("rst_nobeam", 10'd184, 10'd398, 12'hF00, 1'b0, 8'h00, 2'd0, 10'd0);

    @(negedge clk);
    reset = 1'b0;
    bus.shooting = 1'b1;
    run_ticks(1); check_pix("t1_charge", 10'd184, 10'd390, 12'hF00, 1'b0, 8'h00, 2'd1, 10'd0);
    run_ticks(1); check_pix("t2_charge", 10'd184, 10'd390, 12'hF00, 1'b0, 8'h00, 2'd1, 10'd0);
    run_ticks(1);
    for (int i = 0; i < 10; i++) begin
      check_pix($sformatf("fire_tab%0d", i), fire_tab[i].px, fire_tab[i].py, fire_tab[i].rgb,
                fire_tab[i].on, fire_tab[i].addr, 2'd2, 10'd32);
    end
    run_ticks(1); check_pix("t4_len64", 10'd184, 10'd340, 12'hF00, 1'b1, 8'h40, 2'd2, 10'd64);
    run_ticks(1); check_pix("t5_len96", 10'd184, 10'd390, 12'hF00, 1'b1, 8'h60, 2'd2, 10'd96);
    run_ticks(1); check_pix("t6_len128", 10'd184, 10'd390, 12'hF00, 1'b1, 8'h60, 2'd2, 10'd128);
    run_ticks(1); check_pix("overheat", 10'd184, 10'd390, 12'hF00, 1'b0, 8'h00, 2'd3, 10'd0);
    run_ticks(1); check_pix("cool1", 10'd184, 10'd390, 12'hF00, 1'b0, 8'h00, 2'd3, 10'd0);
    run_ticks(1); check_pix("cool_done", 10'd184, 10'd390, 12'hF00, 1'b0, 8'h00, 2'd0, 10'd0);
    run_ticks(1); check_pix("recharge", 10'd184, 10'd390, 12'hF00, 1'b0, 8'h00, 2'd1, 10'd0);

    bus.shooting = 1'b0;
    run_ticks(1); check_pix("charge_release", 10'd184, 10'd390, 12'hF00, 1'b0, 8'h00, 2'd0, 10'd0);
    run_cycles(1); bus.shooting = 1'b1;
    run_cycles(1); bus.shooting = 1'b0;
    run_cycles(2); check_pix("pulse_ignored", 10'd184, 10'd390, 12'hF00, 1'b0, 8'h00, 2'd0, 10'd0);

    bus.shooting = 1'b1;
    run_ticks(2); check_pix("rel_charge", 10'd184, 10'd390, 12'hF00, 1'b0, 8'h00, 2'd1, 10'd0);
    run_ticks(1); check_pix("rel_fire", 10'd184, 10'd390, 12'hF00, 1'b1, 8'h60, 2'd2, 10'd32);
    bus.shooting = 1'b0;
    run_ticks(1); check_pix("fire_release", 10'd184, 10'd390, 12'hF00, 1'b0, 8'h00, 2'd3, 10'd0);
    run_ticks(2); check_pix("rel_idle", 10'd184, 10'd390, 12'hF00, 1'b0, 8'h00, 2'd0, 10'd0);

    // left edge: origin clamps to 0, beam 0 would start at -20
    bus.player_x = 10'd4;
    bus.shooting = 1'b1;
    run_ticks(3);
    check_pix("clipL_b1_lo", 10'd0,  10'd390, 12'hF00, 1'b1, 8'h60, 2'd2, 10'd32);
    check_pix("clipL_b1_hi", 10'd15, 10'd390, 12'hF00, 1'b1, 8'h6F, 2'd2, 10'd32);
    check_pix("clipL_gap",   10'd16, 10'd390, 12'hF00, 1'b0, 8'h00, 2'd2, 10'd32);
    check_pix("clipL_b2_lo", 10'd20, 10'd390, 12'hF00, 1'b1, 8'h60, 2'd2, 10'd32);
    check_pix("clipL_b2_hi", 10'd35, 10'd390, 12'hF00, 1'b1, 8'h6F, 2'd2, 10'd32);
    // right edge: origin 372, beams 1 and 2 cross MAX_X
    bus.player_x = 10'd380;
    run_ticks(1);
    check_pix("clipR_b0_lo", 10'd352, 10'd390, 12'hF00, 1'b1, 8'h60, 2'd2, 10'd64);
    check_pix("clipR_b0_hi", 10'd367, 10'd390, 12'hF00, 1'b1, 8'h6F, 2'd2, 10'd64);
    check_pix("clipR_b1",    10'd372, 10'd390, 12'hF00, 1'b0, 8'h00, 2'd2, 10'd64);
    check_pix("clipR_b1b",   10'd380, 10'd390, 12'hF00, 1'b0, 8'h00, 2'd2, 10'd64);
    bus.shooting = 1'b0;
    run_ticks(3); check_pix("clip_idle", 10'd0, 10'd0, 12'h000, 1'b0, 8'h00, 2'd0, 10'd0);

    // saturation: origin_y 39
    bus.player_x = 10'd192;
    bus.player_y = 10'd40;
    bus.shooting = 1'b1;
    run_ticks(3); check_pix("sat_entry", 10'd184, 10'd10, 12'hF00, 1'b1, 8'hA0, 2'd2, 10'd32);
    run_ticks(1);
    check_pix("sat_row0",  10'd184, 10'd0,    12'hF00, 1'b1, 8'h00, 2'd2, 10'd39);
    check_pix("sat_row38", 10'd184, 10'd38,   12'hF00, 1'b1, 8'h60, 2'd2, 10'd39);
    check_pix("sat_row39", 10'd184, 10'd39,   12'hF00, 1'b0, 8'h00, 2'd2, 10'd39);
    check_pix("sat_nowrap", 10'd184, 10'd1023, 12'hF00, 1'b0, 8'h00, 2'd2, 10'd39);
    check_pix("transparent", 10'd184, 10'd10, 12'h000, 1'b0, 8'hA0, 2'd2, 10'd39);
    run_ticks(1); check_pix("sat_hold", 10'd184, 10'd20, 12'hF00, 1'b1, 8'h40, 2'd2, 10'd39);

    // asynchronous reset between ticks while firing
    run_cycles(1);
    reset = 1'b1;
    #1;
    check_pix("arst_midfire", 10'd184, 10'd10, 12'hF00, 1'b0, 8'h00, 2'd0, 10'd0);
    bus.player_y = 10'(SPAWN_Y);
    @(negedge clk);
    reset = 1'b0;
    run_ticks(2); check_pix("arst_recharge", 10'd184, 10'd390, 12'hF00, 1'b0, 8'h00, 2'd1, 10'd0);
    run_ticks(1); check_pix("arst_refire", 10'd184, 10'd390, 12'hF00, 1'b1, 8'h60, 2'd2, 10'd32);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
